shift_pipe: RTL and testbench
=============================

// Module: shift_pipe
// PURPOSE
//  Parametrised, pipelined barrel shifter/rotator. It replaces the fixed 16-bit combinational shift-left
//  with a WIDTH-bit unit supporting ROL/SLL/ROR/SRA, a valid/ready handshake and STAGES register stages.
//  It sits in the execute stage as the shift unit and can be pipelined to meet timing.
//  A user tag travels with each operation so results can be matched to their issue.
// PARAMETERS
//  WIDTH   16  data width; power of two, >= 4
//  STAGES  1   register stages, 1..CNT_W; latency in cycles
//  TAG_W   4   sideband tag width, passed through unchanged
//  CNT_W   derived = $clog2(WIDTH); not overridable
// PORTS
//  clk        in   1      clock; all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operation present on in_*
//  in_ready   out  1      unit accepts operation this cycle
//  in_data    in   WIDTH  operand
//  in_cnt     in   CNT_W  shift amount 0..WIDTH-1
//  in_op      in   2      00 ROL, 01 SLL, 10 ROR, 11 SRA
//  in_tag     in   TAG_W  sideband, returned on out_tag
//  out_valid  out  1      result present on out_*
//  out_ready  in   1      consumer accepts result
//  out_data   out  WIDTH  shifted/rotated result
//  out_zero   out  1      out_data == 0
//  out_ill    out  1      op was illegal in this build (see CONFIGURATION)
//  out_tag    out  TAG_W  tag of this result
// BEHAVIOUR
//  - Reset (async, rst_n=0): all stage valid bits 0, out_valid=0, out_data=0, out_zero=0, out_ill=0,
//    out_tag=0. in_ready is 1 as soon as rst_n=1. Reset mid-operation discards every in-flight op.
//  - Datapath: CNT_W binary sub-stages, amount 2^k for k=0..CNT_W-1, each enabled by in_cnt[k].
//    Sub-stage k lives in pipe stage floor(k*STAGES/CNT_W). A register follows the last sub-stage
//    of each pipe stage, so the final stage register drives out_*.
//  - Op semantics: SLL fills with 0; SRA fills with in_data[WIDTH-1]; ROL/ROR wrap modulo WIDTH.
//    cnt=0 passes in_data unchanged for every op. No shift amount >= WIDTH is representable.
//  - Handshake: an op transfers on in_valid & in_ready, and a result transfers on out_valid & out_ready.
//    Stage i advances when it is empty or when stage i+1 advances. in_ready = !v0 | advance0, which is
//    a combinational chain from out_ready. There are no bubbles: full throughput is 1 op/clk while
//    out_ready=1.
//  - Latency: an op accepted in cycle t appears with out_valid=1 in cycle t+STAGES.
//  - Backpressure: with out_ready=0 all stage contents, out_* and ordering hold. After STAGES further
//    accepts, in_ready=0. While out_valid=1 & out_ready=0, out_* must not change.
//  - Simultaneous accept and drain with the pipe full: both occur in the same cycle, with no loss or
//    duplication.
//  - in_* values are don't-care when in_valid=0. Those cycles never alter any stage contents.
//  - out_zero and out_ill are registered with the data in the final stage.
// CONFIGURATION
//  ROTATE_EN defined:  ROL and ROR are implemented as above; out_ill is always 0.
//  ROTATE_EN absent:   the wrap logic is removed. ROL/ROR ops are still accepted and timed normally,
//                      but return out_data=0, out_zero=1, out_ill=1. SLL/SRA are unaffected.
// TESTING
//  1. WIDTH=16,STAGES=1: SLL 0x00F3 cnt=4 -> 0x0F30 one cycle after accept, out_zero=0.
//  2. SRA 0x8001 cnt=15 -> 0xFFFF; SRA 0x7FFF cnt=15 -> 0x0000, out_zero=1.
//  3. ROTATE_EN: ROL 0x8001 cnt=1 -> 0x0003; ROR 0x0003 cnt=1 -> 0x8001. Without ROTATE_EN both
//     -> 0x0000, out_ill=1.
//  4. STAGES=4: 8 back-to-back ops, tags 0..7, out_ready=1 -> results in cycles t+4..t+11, in order.
//  5. STAGES=2: hold out_ready=0 -> in_ready drops after 2 accepts and out_* stays stable.
//     Release -> 1 result/clk, no loss.
//  6. Assert rst_n=0 with the pipe full -> out_valid=0 immediately. After release, the first new op
//     returns its own tag.

Source files
------------

// File: rtl/shift_pipe_if.sv
// Handshake bundle for the pipelined shift unit (issue side in_*, result side out_*).
// Shared by the unit (slave) and whoever issues operations and consumes results (master).
interface shift_pipe_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  localparam int CNT_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [CNT_W-1:0] in_cnt;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_ill;
  logic [TAG_W-1:0] out_tag;

  // Valid/ready: a beat transfers on a rising edge where valid and ready are both 1.
  // While valid=1 and ready=0, the producer holds its payload unchanged.
  // The unit's in_ready depends combinationally on out_ready.
  // The unit never drops out_valid before the result has transferred.
  modport master (
    output in_valid, in_data, in_cnt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_ill, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_cnt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_ill, out_tag
  );
endinterface

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter/rotator (ROL/SLL/ROR/SRA) with tag sideband and valid/ready flow control.
// Define ROTATE_EN to build the rotate datapath; without it ROL/ROR return 0 with out_ill set.
module shift_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input logic         clk,
  input logic         rst_n,
  shift_pipe_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam int LAST  = STAGES - 1;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b11;

  // Stage registers; entry i is the output register of pipe stage i.
  logic [STAGES-1:0] validQ;
  logic [WIDTH-1:0]  dataQ [STAGES];
  logic [TAG_W-1:0]  tagQ  [STAGES];
  logic              zeroQ;
  logic              illQ;

  // Per-stage inputs, results and advance enables.
  logic [STAGES-1:0] stValid;
  logic [WIDTH-1:0]  stData [STAGES];
  logic [CNT_W-1:0]  stCnt  [STAGES];
  logic [1:0]        stOp   [STAGES];
  logic [TAG_W-1:0]  stTag  [STAGES];
  logic [WIDTH-1:0]  stOut  [STAGES];
  logic [STAGES-1:0] adv;

  logic              lastIll;
  logic [WIDTH-1:0]  lastRes;

  // One binary sub-stage: move x by 2^k positions according to op.
  function automatic logic [WIDTH-1:0] shiftStep(input logic [WIDTH-1:0] x,
                                                 input logic [1:0] op, input int k);
    logic [WIDTH-1:0] r;
    int amt;
    amt = 1 << k;
    case (op)
      OP_SLL: r = x << amt;
      OP_SRA: r = $unsigned($signed(x) >>> amt);
`ifdef ROTATE_EN
      OP_ROL: r = (x << amt) | (x >> (WIDTH - amt));
      default: r = (x >> amt) | (x << (WIDTH - amt));
`else
      default: r = '0;
`endif
    endcase
    return r;
  endfunction

  assign stValid[0] = bus.in_valid;
  assign stData[0]  = bus.in_data;
  assign stCnt[0]   = bus.in_cnt;
  assign stOp[0]    = bus.in_op;
  assign stTag[0]   = bus.in_tag;

  for (genvar s = 1; s < STAGES; s++) begin : g_fwd
    assign stValid[s] = validQ[s-1];
    assign stData[s]  = dataQ[s-1];
    assign stTag[s]   = tagQ[s-1];
  end

  // Count and op are only needed by stages that still have sub-stages to apply.
  if (STAGES > 1) begin : g_ctrl
    logic [CNT_W-1:0] cntQ [STAGES-1];
    logic [1:0]       opQ  [STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < STAGES - 1; s++) begin
          cntQ[s] <= '0;
          opQ[s]  <= '0;
        end
      end else begin
        for (int s = 0; s < STAGES - 1; s++) begin
          if (adv[s] && stValid[s]) begin
            cntQ[s] <= stCnt[s];
            opQ[s]  <= stOp[s];
          end
        end
      end
    end

    for (genvar s = 1; s < STAGES; s++) begin : g_ctrl_fwd
      assign stCnt[s] = cntQ[s-1];
      assign stOp[s]  = opQ[s-1];
    end
  end

  // Stage i advances if any stage from i onward is empty or the consumer takes the result.
  always_comb begin
    logic allFull;
    allFull = 1'b1;
    adv     = '0;
    for (int s = LAST; s >= 0; s--) begin
      allFull = allFull & validQ[s];
      adv[s]  = bus.out_ready | !allFull;
    end
  end

  // Sub-stage k belongs to pipe stage floor(k*STAGES/CNT_W).
  always_comb begin
    logic [WIDTH-1:0] acc;
    acc = '0;
    for (int s = 0; s < STAGES; s++) begin
      acc = stData[s];
      for (int k = 0; k < CNT_W; k++) begin
        if (((k * STAGES) / CNT_W) == s && stCnt[s][k]) begin
          acc = shiftStep(acc, stOp[s], k);
        end
      end
      stOut[s] = acc;
    end
  end

`ifdef ROTATE_EN
  assign lastIll = 1'b0;
`else
  assign lastIll = !stOp[LAST][0];
`endif
  assign lastRes = lastIll ? '0 : stOut[LAST];

  // Payload only loads with a valid op, so idle cycles never disturb stage contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validQ <= '0;
      zeroQ  <= 1'b0;
      illQ   <= 1'b0;
      for (int s = 0; s < STAGES; s++) begin
        dataQ[s] <= '0;
        tagQ[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (adv[s]) begin
          validQ[s] <= stValid[s];
          if (stValid[s]) begin
            dataQ[s] <= (s == LAST) ? lastRes : stOut[s];
            tagQ[s]  <= stTag[s];
          end
        end
      end
      if (adv[LAST] && stValid[LAST]) begin
        zeroQ <= (lastRes == '0);
        illQ  <= lastIll;
      end
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = validQ[LAST];
  assign bus.out_data  = dataQ[LAST];
  assign bus.out_tag   = tagQ[LAST];
  assign bus.out_zero  = zeroQ;
  assign bus.out_ill   = illQ;
endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe: three instances (STAGES 1, 2, 4) exercised one at a time against a
// bit-level reference model with an expected queue, plus literal checks on key results.
module tb_shift_pipe;
  localparam int WIDTH = 16;
  localparam int TAG_W = 4;
  localparam int EXP_W = 32 + TAG_W + WIDTH + 2;

  localparam logic [1:0] ROL = 2'b00;
  localparam logic [1:0] SLL = 2'b01;
  localparam logic [1:0] ROR = 2'b10;
  localparam logic [1:0] SRA = 2'b11;

  // Clock/reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  // Stimulus shared by all lanes; only lane "cur" sees in_valid.
  logic             inValid;
  logic [WIDTH-1:0] inData;
  logic [3:0]       inCnt;
  logic [1:0]       inOp;
  logic [TAG_W-1:0] inTag;
  logic             outReady;
  int               cur;

  shift_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus0 ();
  shift_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus1 ();
  shift_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus2 ();

  shift_pipe #(.WIDTH(WIDTH), .STAGES(1), .TAG_W(TAG_W)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  shift_pipe #(.WIDTH(WIDTH), .STAGES(2), .TAG_W(TAG_W)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  shift_pipe #(.WIDTH(WIDTH), .STAGES(4), .TAG_W(TAG_W)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus0.in_valid = inValid && (cur == 0);
  assign bus1.in_valid = inValid && (cur == 1);
  assign bus2.in_valid = inValid && (cur == 2);
  assign bus0.in_data = inData;  assign bus1.in_data = inData;  assign bus2.in_data = inData;
  assign bus0.in_cnt  = inCnt;   assign bus1.in_cnt  = inCnt;   assign bus2.in_cnt  = inCnt;
  assign bus0.in_op   = inOp;    assign bus1.in_op   = inOp;    assign bus2.in_op   = inOp;
  assign bus0.in_tag  = inTag;   assign bus1.in_tag  = inTag;   assign bus2.in_tag  = inTag;
  assign bus0.out_ready = (cur == 0) ? outReady : 1'b1;
  assign bus1.out_ready = (cur == 1) ? outReady : 1'b1;
  assign bus2.out_ready = (cur == 2) ? outReady : 1'b1;

  logic             curInReady, curOutValid, curOutZero, curOutIll;
  logic [WIDTH-1:0] curOutData;
  logic [TAG_W-1:0] curOutTag;

  always_comb begin
    curInReady  = bus2.in_ready;
    curOutValid = bus2.out_valid;
    curOutData  = bus2.out_data;
    curOutZero  = bus2.out_zero;
    curOutIll   = bus2.out_ill;
    curOutTag   = bus2.out_tag;
    if (cur == 0) begin
      curInReady  = bus0.in_ready;
      curOutValid = bus0.out_valid;
      curOutData  = bus0.out_data;
      curOutZero  = bus0.out_zero;
      curOutIll   = bus0.out_ill;
      curOutTag   = bus0.out_tag;
    end else if (cur == 1) begin
      curInReady  = bus1.in_ready;
      curOutValid = bus1.out_valid;
      curOutData  = bus1.out_data;
      curOutZero  = bus1.out_zero;
      curOutIll   = bus1.out_ill;
      curOutTag   = bus1.out_tag;
    end
  end

  // Scoreboard state
  int errors = 0;
  int checks = 0;
  logic [EXP_W-1:0] exp_q[$];
  int               popCount = 0;
  logic [WIDTH-1:0] lastData;
  logic [TAG_W-1:0] lastTag;
  logic             lastZero, lastIll;
  int               lastLat;
  bit               strictLat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic int laneStages(input int l);
    return (l == 0) ? 1 : ((l == 1) ? 2 : 4);
  endfunction

  // Reference: each output bit picked from its source bit by the op's rule.
  function automatic logic [WIDTH-1:0] modelShift(input logic [WIDTH-1:0] d,
                                                  input logic [3:0] c, input logic [1:0] op);
    logic [WIDTH-1:0] r;
    int ci;
    ci = int'(c);
    r  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (op)
        ROL: r[i] = d[(i - ci + WIDTH) % WIDTH];
        SLL: r[i] = (i >= ci) ? d[i - ci] : 1'b0;
        ROR: r[i] = d[(i + ci) % WIDTH];
        default: r[i] = (i + ci < WIDTH) ? d[i + ci] : d[WIDTH-1];
      endcase
    end
    return r;
  endfunction

  function automatic logic modelIll(input logic [1:0] op);
`ifdef ROTATE_EN
    return 1'b0;
`else
    return !op[0];
`endif
  endfunction

  // Compare process: samples on the falling edge, mid-cycle.
  logic             prevHold = 1'b0;
  logic [WIDTH-1:0] snapData;
  logic [TAG_W-1:0] snapTag;
  logic             snapZero, snapIll;

  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    logic [WIDTH-1:0] md;
    logic             mi;
    if (!rst_n) begin
      prevHold = 1'b0;
    end else begin
      if (prevHold) begin
        check("hold_valid", curOutValid, 1);
        check("hold_data", curOutData, snapData);
        check("hold_tag", curOutTag, snapTag);
        check("hold_zero", curOutZero, snapZero);
        check("hold_ill", curOutIll, snapIll);
      end
      if (inValid && curInReady) begin
        mi = modelIll(inOp);
        md = mi ? '0 : modelShift(inData, inCnt, inOp);
        exp_q.push_back({32'(cycle), inTag, md, (md == '0), mi});
      end
      if (curOutValid && outReady) begin
        if (exp_q.size() == 0) begin
          fail("spurious_result");
        end else begin
          e = exp_q.pop_front();
          check("out_data", curOutData, e[2 +: WIDTH]);
          check("out_tag", curOutTag, e[WIDTH+2 +: TAG_W]);
          check("out_zero", curOutZero, e[1]);
          check("out_ill", curOutIll, e[0]);
          lastLat = cycle - int'(e[EXP_W-1 -: 32]);
          if (strictLat) check("latency", lastLat, laneStages(cur));
          lastData = curOutData;
          lastTag  = curOutTag;
          lastZero = curOutZero;
          lastIll  = curOutIll;
          popCount++;
        end
      end
      prevHold = curOutValid && !outReady;
      snapData = curOutData;
      snapTag  = curOutTag;
      snapZero = curOutZero;
      snapIll  = curOutIll;
    end
  end

  // Driver: called just after a rising edge; returns just after the edge that accepted the op.
  task automatic sendOp(input logic [1:0] op, input logic [WIDTH-1:0] d,
                        input logic [3:0] c, input logic [TAG_W-1:0] t);
    int  n;
    bit  done;
    n    = 0;
    done = 0;
    inValid = 1'b1;
    inOp    = op;
    inData  = d;
    inCnt   = c;
    inTag   = t;
    while (!done && n < 200) begin
      @(negedge clk);
      if (curInReady) done = 1;
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) fail("accept_timeout");
    inValid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    fail("global_timeout");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int p0;
    inValid = 0; inData = '0; inCnt = '0; inOp = '0; inTag = '0;
    outReady = 1; cur = 0; strictLat = 1; rst_n = 0;

    #12;
    check("rst_valid0", bus0.out_valid, 0);
    check("rst_data0", bus0.out_data, 0);
    check("rst_zero0", bus0.out_zero, 0);
    check("rst_ill0", bus0.out_ill, 0);
    check("rst_tag0", bus0.out_tag, 0);
    check("rst_valid2", bus2.out_valid, 0);
    check("rst_data2", bus2.out_data, 0);
    #10;
    rst_n = 1;
    #1;
    check("rst_in_ready0", bus0.in_ready, 1);
    check("rst_in_ready2", bus2.in_ready, 1);
    @(posedge clk); #1;

    // STAGES=1: literal results
    cur = 0;
    sendOp(SLL, 16'h00F3, 4'd4, 4'h1);
    drain();
    check("sll_data", lastData, 16'h0F30);
    check("sll_zero", lastZero, 0);
    check("sll_tag", lastTag, 4'h1);
    check("sll_lat", lastLat, 1);
    sendOp(SRA, 16'h8001, 4'd15, 4'h2);
    drain();
    check("sra_neg_data", lastData, 16'hFFFF);
    sendOp(SRA, 16'h7FFF, 4'd15, 4'h3);
    drain();
    check("sra_pos_data", lastData, 16'h0000);
    check("sra_pos_zero", lastZero, 1);
    sendOp(ROL, 16'h8001, 4'd1, 4'h4);
    drain();
`ifdef ROTATE_EN
    check("rol_data", lastData, 16'h0003);
    check("rol_ill", lastIll, 0);
`else
    check("rol_data", lastData, 16'h0000);
    check("rol_ill", lastIll, 1);
    check("rol_zero", lastZero, 1);
`endif
    sendOp(ROR, 16'h0003, 4'd1, 4'h5);
    drain();
`ifdef ROTATE_EN
    check("ror_data", lastData, 16'h8001);
`else
    check("ror_data", lastData, 16'h0000);
    check("ror_ill", lastIll, 1);
`endif
    sendOp(SLL, 16'h0001, 4'd15, 4'h6);
    drain();
    check("sll_max_data", lastData, 16'h8000);

    // STAGES=2: back-to-back directed table, cnt=0 and boundary amounts
    cur = 1;
    sendOp(SRA, 16'hA5A5, 4'd0, 4'h0);
    sendOp(SLL, 16'hFFFF, 4'd15, 4'h1);
    sendOp(SRA, 16'h8000, 4'd4, 4'h2);
    sendOp(ROR, 16'h1234, 4'd4, 4'h3);
    sendOp(ROL, 16'h1234, 4'd8, 4'h4);
    sendOp(SLL, 16'h1234, 4'd0, 4'h5);
    sendOp(SRA, 16'h4000, 4'd14, 4'h6);
    sendOp(ROR, 16'hBEEF, 4'd0, 4'h7);
    drain();
`ifdef ROTATE_EN
    check("ror_cnt0_data", lastData, 16'hBEEF);
`else
    check("ror_cnt0_data", lastData, 16'h0000);
`endif

    // STAGES=4: 8 back-to-back ops, exact latency and order
    cur = 2;
    p0 = popCount;
    for (int i = 0; i < 8; i++) begin
      sendOp(SLL, 16'(i * 16'h1111), 4'(i), 4'(i));
    end
    drain();
    check("b2b_count", popCount - p0, 8);
    check("b2b_last_tag", lastTag, 4'h7);

    // STAGES=2: backpressure, then simultaneous accept and drain
    cur = 1;
    strictLat = 0;
    outReady = 0;
    p0 = popCount;
    sendOp(SLL, 16'h0101, 4'd1, 4'h8);
    sendOp(SRA, 16'hF000, 4'd2, 4'h9);
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", curInReady, 0);
    end
    @(posedge clk); #1;
    outReady = 1;
    sendOp(SRA, 16'h0F0F, 4'd3, 4'hA);
    sendOp(SLL, 16'h00FF, 4'd8, 4'hB);
    sendOp(ROL, 16'h00FF, 4'd12, 4'hC);
    drain();
    check("bp_count", popCount - p0, 5);
    check("bp_last_tag", lastTag, 4'hC);

    // STAGES=4: reset with the pipe full
    cur = 2;
    outReady = 0;
    for (int i = 0; i < 4; i++) begin
      sendOp(SLL, 16'h0003, 4'(i), 4'(i + 1));
    end
    check("full_valid", bus2.out_valid, 1);
    check("full_in_ready", bus2.in_ready, 0);
    #2;
    rst_n = 0;
    #1;
    check("midrst_valid", bus2.out_valid, 0);
    check("midrst_data", bus2.out_data, 0);
    check("midrst_tag", bus2.out_tag, 0);
    exp_q.delete();
    @(negedge clk);
    #2;
    rst_n = 1;
    @(posedge clk); #1;
    outReady = 1;
    strictLat = 1;
    p0 = popCount;
    sendOp(SLL, 16'h0005, 4'd1, 4'hD);
    drain();
    check("post_rst_count", popCount - p0, 1);
    check("post_rst_tag", lastTag, 4'hD);
    check("post_rst_data", lastData, 16'h000A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
